// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - convolution scheduler: vector load, per-point tap issue, MAC drain, output handshake
// One FSM walks LOAD -> (ISSUE -> DRAIN -> OUT) per output point, then back to LOAD.
module conv_sched #(
  parameter int SIZE_X  = 16,
  parameter int SIZE_F  = 8,
  parameter int MAC_LAT = 3,
  localparam int NPTS   = SIZE_X - SIZE_F + 1,
  localparam int AXW    = $clog2(SIZE_X),
  localparam int AFW    = $clog2(SIZE_F),
  localparam int PW     = $clog2(NPTS + 1)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           x_valid_i,
  output logic           x_ready_o,
  output logic           x_wr_en_o,
  output logic [AXW-1:0] addr_x_o,
  output logic [AFW-1:0] addr_f_o,
  output logic           mac_clear_o,
  output logic           mac_en_o,
  output logic           y_valid_o,
  input  logic           y_ready_i,
  output logic [PW-1:0]  y_point_o
);

  localparam int DW = $clog2(MAC_LAT + 2);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t         state_q, state_d;
  logic [AXW-1:0] ld_cnt_q, ld_cnt_d;
  logic [AFW-1:0] tap_q, tap_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [PW-1:0]  y_point_q, y_point_d;
  logic           mac_en_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_LOAD;
      ld_cnt_q  <= '0;
      tap_q     <= '0;
      drain_q   <= '0;
      y_point_q <= '0;
      mac_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      tap_q     <= tap_d;
      drain_q   <= drain_d;
      y_point_q <= y_point_d;
      // memory read latency is one cycle, so the MAC sees each tap one cycle after issue
      mac_en_q  <= (state_q == S_ISSUE);
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    tap_d       = tap_q;
    drain_d     = drain_q;
    y_point_d   = y_point_q;
    x_ready_o   = 1'b0;
    x_wr_en_o   = 1'b0;
    addr_x_o    = '0;
    addr_f_o    = '0;
    mac_clear_o = 1'b0;
    y_valid_o   = 1'b0;

    case (state_q)
      S_LOAD: begin
        x_ready_o   = !reset_i;
        x_wr_en_o   = x_valid_i && !reset_i;
        addr_x_o    = ld_cnt_q;
        mac_clear_o = 1'b1;
        if (x_wr_en_o) begin
          if (ld_cnt_q == AXW'(SIZE_X - 1)) begin
            ld_cnt_d  = '0;
            y_point_d = '0;
            state_d   = S_ISSUE;
          end else begin
            ld_cnt_d = ld_cnt_q + AXW'(1);
          end
        end
      end
      S_ISSUE: begin
        addr_x_o    = AXW'(y_point_q) + AXW'(tap_q);
        addr_f_o    = tap_q;
        mac_clear_o = (tap_q == '0);
        if (tap_q == AFW'(SIZE_F - 1)) begin
          tap_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          tap_d = tap_q + AFW'(1);
        end
      end
      S_DRAIN, S_OUT: begin
        // addresses keep showing the last tap until the next point starts
        addr_x_o = AXW'(y_point_q) + AXW'(SIZE_F - 1);
        addr_f_o = AFW'(SIZE_F - 1);
        if (state_q == S_DRAIN) begin
          if (drain_q == DW'(MAC_LAT)) begin
            drain_d = '0;
            state_d = S_OUT;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end else begin
          y_valid_o = 1'b1;
          if (y_ready_i) begin
            if (y_point_q == PW'(NPTS - 1)) begin
              y_point_d = '0;
              state_d   = S_LOAD;
            end else begin
              y_point_d = y_point_q + PW'(1);
              state_d   = S_ISSUE;
            end
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign mac_en_o  = mac_en_q;
  assign y_point_o = y_point_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - directed self-checking bench for conv_sched at default parameters
module tb_conv_sched;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       x_valid_i;
  logic       x_ready_o;
  logic       x_wr_en_o;
  logic [3:0] addr_x_o;
  logic [2:0] addr_f_o;
  logic       mac_clear_o;
  logic       mac_en_o;
  logic       y_valid_o;
  logic       y_ready_i;
  logic [3:0] y_point_o;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  conv_sched dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .x_valid_i   (x_valid_i),
    .x_ready_o   (x_ready_o),
    .x_wr_en_o   (x_wr_en_o),
    .addr_x_o    (addr_x_o),
    .addr_f_o    (addr_f_o),
    .mac_clear_o (mac_clear_o),
    .mac_en_o    (mac_en_o),
    .y_valid_o   (y_valid_o),
    .y_ready_i   (y_ready_i),
    .y_point_o   (y_point_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (!reset_i && y_valid_o && y_ready_i) hs_cnt++;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walks one point from its first ISSUE cycle to its first OUT cycle (12 cycles).
  task automatic do_point(input int p);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("p%0d_k%0d_addr_x", p, k), 32'(addr_x_o), 32'(p + k));
      check($sformatf("p%0d_k%0d_addr_f", p, k), 32'(addr_f_o), 32'(k));
      check($sformatf("p%0d_k%0d_clear", p, k), 32'(mac_clear_o), (k == 0) ? 32'd1 : 32'd0);
      check($sformatf("p%0d_k%0d_mac_en", p, k), 32'(mac_en_o), (k == 0) ? 32'd0 : 32'd1);
      check($sformatf("p%0d_k%0d_y_valid", p, k), 32'(y_valid_o), 32'd0);
      check($sformatf("p%0d_k%0d_x_wr_en", p, k), 32'(x_wr_en_o), 32'd0);
      check($sformatf("p%0d_k%0d_y_point", p, k), 32'(y_point_o), 32'(p));
      step();
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("p%0d_d%0d_mac_en", p, d), 32'(mac_en_o), (d == 0) ? 32'd1 : 32'd0);
      check($sformatf("p%0d_d%0d_y_valid", p, d), 32'(y_valid_o), 32'd0);
      check($sformatf("p%0d_d%0d_addr_x", p, d), 32'(addr_x_o), 32'(p + 7));
      check($sformatf("p%0d_d%0d_clear", p, d), 32'(mac_clear_o), 32'd0);
      step();
    end
    check($sformatf("p%0d_out_y_valid", p), 32'(y_valid_o), 32'd1);
    check($sformatf("p%0d_out_y_point", p), 32'(y_point_o), 32'(p));
    check($sformatf("p%0d_out_mac_en", p), 32'(mac_en_o), 32'd0);
    check($sformatf("p%0d_out_addr_f", p), 32'(addr_f_o), 32'd7);
  endtask

  task automatic load_full(input string tag);
    for (int i = 0; i < 16; i++) begin
      x_valid_i = 1'b1;
      #1;
      check($sformatf("%s_wr_en_%0d", tag, i), 32'(x_wr_en_o), 32'd1);
      check($sformatf("%s_addr_x_%0d", tag, i), 32'(addr_x_o), 32'(i));
      check($sformatf("%s_clear_%0d", tag, i), 32'(mac_clear_o), 32'd1);
      step();
    end
    check($sformatf("%s_x_ready_after", tag), 32'(x_ready_o), 32'd0);
    check($sformatf("%s_wr_en_after", tag), 32'(x_wr_en_o), 32'd0);
  endtask

  initial begin
    int exp_cnt;
    int iter;

    reset_i   = 1'b1;
    x_valid_i = 1'b0;
    y_ready_i = 1'b0;
    step();
    step();
    check("rst_x_ready", 32'(x_ready_o), 32'd0);
    check("rst_y_valid", 32'(y_valid_o), 32'd0);
    check("rst_mac_en", 32'(mac_en_o), 32'd0);
    check("rst_mac_clear", 32'(mac_clear_o), 32'd1);
    check("rst_addr_x", 32'(addr_x_o), 32'd0);
    check("rst_addr_f", 32'(addr_f_o), 32'd0);
    check("rst_y_point", 32'(y_point_o), 32'd0);
    reset_i = 1'b0;
    #1;
    check("post_rst_x_ready", 32'(x_ready_o), 32'd1);

    // vector 1: continuous load, stalled output on point 0, then free-running handshakes
    load_full("ld1");
    do_point(0);
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("stall_%0d_y_valid", c), 32'(y_valid_o), 32'd1);
      check($sformatf("stall_%0d_mac_en", c), 32'(mac_en_o), 32'd0);
      check($sformatf("stall_%0d_y_point", c), 32'(y_point_o), 32'd0);
      check($sformatf("stall_%0d_x_wr_en", c), 32'(x_wr_en_o), 32'd0);
    end
    check("stall_hs", 32'(hs_cnt), 32'd0);
    y_ready_i = 1'b1;
    for (int p = 1; p < 9; p++) begin
      step();
      do_point(p);
    end
    step();
    check("v1_hs", 32'(hs_cnt), 32'd9);
    check("v1_back_x_ready", 32'(x_ready_o), 32'd1);
    check("v1_back_y_valid", 32'(y_valid_o), 32'd0);
    check("v1_back_y_point", 32'(y_point_o), 32'd0);

    // vector 2: sparse x_valid, then reset mid-ISSUE of point 4
    y_ready_i = 1'b0;
    exp_cnt = 0;
    iter = 0;
    while (exp_cnt < 16 && iter < 200) begin
      x_valid_i = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("ld2_addr_x_it%0d", iter), 32'(addr_x_o), 32'(exp_cnt));
      check($sformatf("ld2_wr_en_it%0d", iter), 32'(x_wr_en_o), 32'(x_valid_i));
      step();
      if (x_valid_i) exp_cnt++;
      iter++;
    end
    check("ld2_done", 32'(exp_cnt), 32'd16);
    x_valid_i = 1'b1;
    y_ready_i = 1'b1;
    do_point(0);
    for (int p = 1; p < 4; p++) begin
      step();
      do_point(p);
    end
    step();
    step();
    step();
    check("p4_mid_addr_x", 32'(addr_x_o), 32'd6);
    check("p4_mid_addr_f", 32'(addr_f_o), 32'd2);
    reset_i = 1'b1;
    #1;
    check("rst_issue_x_ready", 32'(x_ready_o), 32'd0);
    check("rst_issue_wr_en", 32'(x_wr_en_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    check("after_rst_issue_x_ready", 32'(x_ready_o), 32'd1);
    check("after_rst_issue_y_valid", 32'(y_valid_o), 32'd0);
    check("after_rst_issue_y_point", 32'(y_point_o), 32'd0);
    check("after_rst_issue_addr_x", 32'(addr_x_o), 32'd0);
    check("after_rst_issue_mac_en", 32'(mac_en_o), 32'd0);
    check("v2_hs", 32'(hs_cnt), 32'd13);

    // vector 3: full run, reset while point 8 is presented
    load_full("ld3");
    do_point(0);
    for (int p = 1; p < 9; p++) begin
      step();
      do_point(p);
      if (p == 7) y_ready_i = 1'b1;
      if (p == 8) y_ready_i = 1'b0;
    end
    step();
    y_ready_i = 1'b0;
    #1;
    check("p8_hold_y_valid", 32'(y_valid_o), 32'd1);
    check("p8_hold_y_point", 32'(y_point_o), 32'd8);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check("after_rst_out_x_ready", 32'(x_ready_o), 32'd1);
    check("after_rst_out_y_valid", 32'(y_valid_o), 32'd0);
    check("after_rst_out_y_point", 32'(y_point_o), 32'd0);
    check("after_rst_out_clear", 32'(mac_clear_o), 32'd1);
    check("v3_hs", 32'(hs_cnt), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter SIZE_X, default 16, number of input samples per vector.
REQ-002 Parameter SIZE_F, default 8, number of filter taps; legal range 2 <= SIZE_F <= SIZE_X.
REQ-003 Parameter MAC_LAT, default 3, cycles from mac_en sampled high to the accumulator register holding that term.
REQ-004 Localparams: NPTS = SIZE_X-SIZE_F+1; AXW = $clog2(SIZE_X); AFW = $clog2(SIZE_F); PW = $clog2(NPTS+1).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 x_valid  in  1  upstream sample valid.
REQ-008 x_ready  out  1  block can accept a sample.
REQ-009 x_wr_en  out  1  write strobe to x memory.
REQ-010 addr_x  out  AXW  x memory address (write during LOAD, read during ISSUE).
REQ-011 addr_f  out  AFW  filter ROM address.
REQ-012 mac_clear  out  1  accumulator clear.
REQ-013 mac_en  out  1  accumulate current memory outputs.
REQ-014 y_valid  out  1  accumulator holds a finished output point.
REQ-015 y_ready  in  1  downstream accepts the point.
REQ-016 y_point  out  PW  index of the point being computed or presented.

Function
REQ-017 States: LOAD, ISSUE, DRAIN, OUT; exactly one active; all outputs except x_wr_en are registered or decoded from state/counters only.
REQ-018 LOAD: x_ready=1; x_wr_en = x_valid & x_ready; addr_x = load count (0..SIZE_X-1), incremented on each write; mac_clear=1.
REQ-019 LOAD -> ISSUE on the write with load count SIZE_X-1; load count returns to 0; y_point=0.
REQ-020 x_ready=0 and x_wr_en=0 in every state other than LOAD; x_valid ignored outside LOAD.
REQ-021 ISSUE lasts exactly SIZE_F cycles, tap k=0..SIZE_F-1: addr_f=k, addr_x=y_point+k.
REQ-022 mac_clear=1 in the first ISSUE cycle of every point; 0 elsewhere in ISSUE, DRAIN and OUT.
REQ-023 mac_en is the ISSUE-tap strobe delayed one cycle (memory read latency 1): high for exactly SIZE_F consecutive cycles per point, first in the second ISSUE cycle.
REQ-024 ISSUE -> DRAIN after tap SIZE_F-1; DRAIN lasts 1+MAC_LAT cycles, then OUT.
REQ-025 Latency: y_valid rises SIZE_F+1+MAC_LAT cycles after the first ISSUE cycle (12 at defaults).
REQ-026 OUT: y_valid=1, mac_en=0, mac_clear=0; held until y_valid & y_ready; addresses hold last value.
REQ-027 On handshake with y_point < NPTS-1: y_point increments, next cycle is ISSUE (with mac_clear per REQ-022).
REQ-028 On handshake with y_point = NPTS-1: next state LOAD, y_point=0, new vector accepted.
REQ-029 y_ready while not in OUT has no effect; y_valid never drops without a handshake.
REQ-030 y_point never exceeds NPTS-1; addr_x never exceeds SIZE_X-1; addr_f never exceeds SIZE_F-1.

Reset
REQ-031 While reset=1 and the first cycle after: state LOAD, counters 0, addr_x=0, addr_f=0, y_point=0, y_valid=0, mac_en=0, mac_clear=1; x_ready=0 while reset=1, 1 from the first cycle reset=0.
REQ-032 Reset asserted in any state (mid-load, mid-issue, while y_valid=1) aborts the operation within the same edge; partial vector discarded, no y handshake credited.

Verification
REQ-033 Reset, then 16 samples with x_valid=1 continuously -> x_wr_en high 16 cycles, addr_x 0..15, x_ready=0 the cycle after the 16th write.
REQ-034 Point 0 at defaults -> addr_f 0..7 and addr_x 0..7 over 8 cycles, mac_en high exactly 8 cycles one cycle later, y_valid high 12 cycles after first ISSUE cycle.
REQ-035 y_ready held 0 for 20 cycles during OUT -> y_valid stays 1, mac_en 0, y_point stable; y_ready=1 -> point 1 issues addr_x 1..8.
REQ-036 y_ready=1 always -> exactly 9 y handshakes with y_point 0..8, then x_ready=1 and second vector loads correctly.
REQ-037 x_valid toggled randomly during LOAD -> load count advances only on x_valid=1 cycles; x_valid=1 in ISSUE/OUT -> no x_wr_en.
REQ-038 Reset pulsed in ISSUE of point 4 and while y_valid=1 of point 8 -> next cycle state LOAD, y_valid=0, y_point=0, x_ready=1.
